// File: rtl/dmem_bus_bridge_if.sv
// Word-addressed valid/grant data bus between the MEM-stage bridge (master)
// and the data-memory side (slave).
interface dmem_bus_bridge_if #(
    parameter int XLEN = 32,
    parameter int ALEN = 32
);
    logic            bus_req;
    logic            bus_we;
    logic [ALEN-1:0] bus_addr;
    logic [XLEN-1:0] bus_wdata;
    logic [3:0]      bus_be;
    logic            bus_gnt;
    logic            bus_rvalid;
    logic [XLEN-1:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/dmem_bus_bridge.sv
// MEM-stage to valid/grant data-bus bridge: stalls the pipeline per access and returns aligned,
// extended load data. Define DMEM_MISALIGN_CHECK_EN to trap misaligned half/word accesses.
module dmem_bus_bridge #(
    parameter int XLEN        = 32,
    parameter int ALEN        = 32,
    parameter int BUS_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ALEN-1:0]      dmem_addr,
    input  logic [XLEN-1:0]      dmem_wdata,
    input  logic                 dmem_we,
    input  logic                 dmem_re,
    input  logic [3:0]           dmem_be,
    input  logic [2:0]           dmem_funct3,
    output logic                 mem_stall,
    output logic [XLEN-1:0]      load_data,
    output logic                 load_valid,
    output logic                 bus_err,
    output logic                 misalign_err,
    dmem_bus_bridge_if.master    bus
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

    localparam int            CW       = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0);
    localparam bit            TO_EN    = (BUS_TIMEOUT > 0);

    state_t          state_q, state_d;
    logic [ALEN-1:0] addr_q, addr_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [3:0]      be_q, be_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] load_data_q, load_data_d;
    logic            load_valid_q, load_valid_d;
    logic            bus_err_q, bus_err_d;
    logic            bus_req_c;
    logic            timed_out;

    // Store data is replicated across lanes so the slave can pick any byte/half lane by be.
    function automatic logic [XLEN-1:0] replicate(input logic [XLEN-1:0] w, input logic [1:0] size);
        logic [XLEN-1:0] r;
        case (size)
            2'b00:   r = {(XLEN/8){w[7:0]}};
            2'b01:   r = {(XLEN/16){w[15:0]}};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] rd, input logic [2:0] f3,
                                                input logic [1:0] off);
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] r;
        b = rd[{off, 3'b000} +: 8];
        h = rd[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  r = {{(XLEN-8){b[7]}}, b};
            3'b001:  r = {{(XLEN-16){h[15]}}, h};
            3'b100:  r = {{(XLEN-8){1'b0}}, b};
            3'b101:  r = {{(XLEN-16){1'b0}}, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    assign timed_out = TO_EN && (cnt_q == CNT_LAST);

`ifdef DMEM_MISALIGN_CHECK_EN
    logic misalign_err_q, misalign_err_d;
    logic misaligned;
    assign misaligned = ((dmem_funct3[1:0] == 2'b01) && dmem_addr[0]) ||
                        ((dmem_funct3[1:0] == 2'b10) && (dmem_addr[1:0] != 2'b00));
    assign misalign_err = misalign_err_q;
`else
    assign misalign_err = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        funct3_d     = funct3_q;
        be_d         = be_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        bus_err_d    = 1'b0;
        mem_stall    = 1'b0;
        bus_req_c    = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
        misalign_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (dmem_we || dmem_re) begin
                    mem_stall = 1'b1;
                    addr_d    = dmem_addr;
                    funct3_d  = dmem_funct3;
                    be_d      = dmem_be;
                    we_d      = dmem_we;
                    wdata_d   = replicate(dmem_wdata, dmem_funct3[1:0]);
                    cnt_d     = '0;
`ifdef DMEM_MISALIGN_CHECK_EN
                    if (misaligned) begin
                        state_d        = DONE;
                        misalign_err_d = 1'b1;
                        if (!dmem_we) load_data_d = '0;
                    end else begin
                        state_d = REQ;
                    end
`else
                    state_d = REQ;
`endif
                end
            end
            REQ: begin
                mem_stall = 1'b1;
                bus_req_c = 1'b1;
                if (bus.bus_gnt) begin
                    cnt_d = '0;
                    if (we_q) begin
                        state_d = DONE;
                    end else if (bus.bus_rvalid) begin
                        load_data_d  = extract(bus.bus_rdata, funct3_q, addr_q[1:0]);
                        load_valid_d = 1'b1;
                        state_d      = DONE;
                    end else begin
                        state_d = WAIT_R;
                    end
                end else if (timed_out) begin
                    state_d     = DONE;
                    bus_err_d   = 1'b1;
                    load_data_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_R: begin
                mem_stall = 1'b1;
                if (bus.bus_rvalid) begin
                    load_data_d  = extract(bus.bus_rdata, funct3_q, addr_q[1:0]);
                    load_valid_d = 1'b1;
                    state_d      = DONE;
                end else if (timed_out) begin
                    state_d     = DONE;
                    bus_err_d   = 1'b1;
                    load_data_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                // Pipeline advances this cycle; its next request is taken from IDLE.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            funct3_q     <= '0;
            be_q         <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            funct3_q     <= funct3_d;
            be_q         <= be_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            bus_err_q    <= bus_err_d;
        end
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_err_q <= 1'b0;
        else        misalign_err_q <= misalign_err_d;
    end
`endif

    assign bus.bus_req   = bus_req_c;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = {addr_q[ALEN-1:2], 2'b00};
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_be    = be_q;

    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Directed scoreboard bench for dmem_bus_bridge: a bus slave model answers each request and
// expected bus fields / completion results are queued at drive time and popped on DUT activity.
module tb_dmem_bus_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_we, dmem_re;
    logic [3:0]  dmem_be;
    logic [2:0]  dmem_funct3;
    logic        mem_stall, load_valid, bus_err, misalign_err;
    logic [31:0] load_data;

    dmem_bus_bridge_if #(.XLEN(32), .ALEN(32)) bus_if ();

    dmem_bus_bridge #(.XLEN(32), .ALEN(32), .BUS_TIMEOUT(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_we      (dmem_we),
        .dmem_re      (dmem_re),
        .dmem_be      (dmem_be),
        .dmem_funct3  (dmem_funct3),
        .mem_stall    (mem_stall),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .bus_err      (bus_err),
        .misalign_err (misalign_err),
        .bus          (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } bus_exp_t;

    typedef struct {
        logic        is_load;
        logic [31:0] data;
        logic        err;
        int          stall;
        int          reqs;
    } done_exp_t;

    bus_exp_t    bus_q[$];
    done_exp_t   done_q[$];
    logic [31:0] last_load = 32'h0;
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // gnt_at: index of the REQ cycle that gets bus_gnt (-1 = never).
    // rv_after: cycles from gnt to rvalid (0 = same cycle, -1 = never).
    task automatic run_txn(input string name, input logic we, input logic re,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input logic [2:0] f3,
                           input int gnt_at, input int rv_after, input logic [31:0] rdata,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_data,
                           input logic exp_err, input int exp_stall, input int exp_reqs);
        int        stall = 0;
        int        reqs  = 0;
        int        k     = 0;
        int        gnt_k = -1;
        bit        done  = 0;
        bus_exp_t  bx;
        done_exp_t dx;
        bus_q.push_back('{we: we, addr: {addr[31:2], 2'b00}, wdata: exp_wdata, be: be});
        done_q.push_back('{is_load: (re && !we), data: exp_data, err: exp_err,
                           stall: exp_stall, reqs: exp_reqs});
        @(negedge clk);
        dmem_we = we; dmem_re = re; dmem_addr = addr; dmem_wdata = wdata;
        dmem_be = be; dmem_funct3 = f3;
        #1;
        check({name, "_idle_stall"}, {31'b0, mem_stall}, 32'h1);
        if (mem_stall) stall++;
        while (!done) begin
            @(negedge clk);
            dmem_we = 1'b0; dmem_re = 1'b0;
            bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0;
            if (k > 100) begin
                total++; bad++;
                $error("FAIL %s_bound observed=no_done expected=done_within_100", name);
                if (reqs == 0 && bus_q.size() > 0) void'(bus_q.pop_front());
                if (done_q.size() > 0) void'(done_q.pop_front());
                done = 1;
            end else if (!mem_stall) begin
                if (reqs == 0 && bus_q.size() > 0) void'(bus_q.pop_front());
                dx = done_q.pop_front();
                if (dx.is_load || dx.err) last_load = dx.data;
                check({name, "_stall_cycles"}, stall, dx.stall);
                check({name, "_req_cycles"}, reqs, dx.reqs);
                check({name, "_load_valid"}, {31'b0, load_valid}, {31'b0, dx.is_load && !dx.err});
                check({name, "_bus_err"}, {31'b0, bus_err}, {31'b0, dx.err});
                check({name, "_load_data"}, load_data, last_load);
                check({name, "_misalign"}, {31'b0, misalign_err}, 32'h0);
                $display("txn %s addr=0x%08h stall=%0d req=%0d load_data=0x%08h load_valid=%0b bus_err=%0b",
                         name, addr, stall, reqs, load_data, load_valid, bus_err);
                done = 1;
            end else begin
                if (bus_if.bus_req) begin
                    if (reqs == 0) bx = bus_q.pop_front();
                    check({name, "_bus_addr"}, bus_if.bus_addr, bx.addr);
                    check({name, "_bus_be"}, {28'b0, bus_if.bus_be}, {28'b0, bx.be});
                    check({name, "_bus_wdata"}, bus_if.bus_wdata, bx.wdata);
                    check({name, "_bus_we"}, {31'b0, bus_if.bus_we}, {31'b0, bx.we});
                    if (reqs == gnt_at) begin
                        bus_if.bus_gnt = 1'b1;
                        gnt_k = k;
                    end
                    reqs++;
                end
                if (!we && gnt_k >= 0 && rv_after >= 0 && k == gnt_k + rv_after) begin
                    bus_if.bus_rvalid = 1'b1;
                    bus_if.bus_rdata  = rdata;
                end
                stall++;
            end
            k++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        dmem_addr = '0; dmem_wdata = '0; dmem_we = 1'b0; dmem_re = 1'b0;
        dmem_be = '0; dmem_funct3 = '0;
        bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_mem_stall", {31'b0, mem_stall}, 32'h0);
        check("rst_bus_req", {31'b0, bus_if.bus_req}, 32'h0);
        check("rst_bus_addr", bus_if.bus_addr, 32'h0);
        check("rst_bus_wdata", bus_if.bus_wdata, 32'h0);
        check("rst_load_data", load_data, 32'h0);
        check("rst_flags", {28'b0, load_valid, bus_err, misalign_err, bus_if.bus_we}, 32'h0);
        rst_n = 1'b1;

        //      name        we    re    addr          wdata         be       f3    gnt rv  rdata         exp_wdata     exp_data      err   stall reqs
        run_txn("sw",       1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 4'b1111, 3'd2, 1, -1, 32'h0,        32'hDEADBEEF, 32'h0,        1'b0, 3,  2);
        run_txn("sb",       1'b1, 1'b0, 32'h103, 32'h000000A5, 4'b1000, 3'd0, 0, -1, 32'h0,        32'hA5A5A5A5, 32'h0,        1'b0, 2,  1);
        run_txn("sh",       1'b1, 1'b0, 32'h102, 32'h1234BEEF, 4'b1100, 3'd1, 2, -1, 32'h0,        32'hBEEFBEEF, 32'h0,        1'b0, 4,  3);
        run_txn("lb",       1'b0, 1'b1, 32'h102, 32'h0,        4'b0100, 3'd0, 0, 1,  32'h12805634, 32'h0,        32'hFFFFFF80, 1'b0, 3,  1);
        run_txn("lbu",      1'b0, 1'b1, 32'h102, 32'h0,        4'b0100, 3'd4, 0, 1,  32'h12805634, 32'h0,        32'h00000080, 1'b0, 3,  1);
        run_txn("lh",       1'b0, 1'b1, 32'h102, 32'h0,        4'b1100, 3'd1, 0, 1,  32'h12805634, 32'h0,        32'h00001280, 1'b0, 3,  1);
        run_txn("lhu_lo",   1'b0, 1'b1, 32'h100, 32'h0,        4'b0011, 3'd5, 1, 1,  32'h1234F00D, 32'h0,        32'h0000F00D, 1'b0, 4,  2);
        run_txn("lh_lo",    1'b0, 1'b1, 32'h100, 32'h0,        4'b0011, 3'd1, 1, 1,  32'h1234F00D, 32'h0,        32'hFFFFF00D, 1'b0, 4,  2);
        run_txn("lb_b1",    1'b0, 1'b1, 32'h101, 32'h0,        4'b0010, 3'd0, 0, 3,  32'h12805634, 32'h0,        32'h00000056, 1'b0, 5,  1);
        run_txn("lw_same",  1'b0, 1'b1, 32'h104, 32'h0,        4'b1111, 3'd2, 0, 0,  32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 1'b0, 2,  1);
        run_txn("lw_unal",  1'b0, 1'b1, 32'h103, 32'h0,        4'b1111, 3'd2, 0, 2,  32'h0BADCAFE, 32'h0,        32'h0BADCAFE, 1'b0, 4,  1);
        run_txn("sw_hold",  1'b1, 1'b0, 32'h108, 32'h11223344, 4'b1111, 3'd2, 0, -1, 32'h0,        32'h11223344, 32'h0,        1'b0, 2,  1);
        run_txn("we_re",    1'b1, 1'b1, 32'h001, 32'h00000077, 4'b0010, 3'd0, 0, -1, 32'h0,        32'h77777777, 32'h0,        1'b0, 2,  1);
        run_txn("to_req",   1'b0, 1'b1, 32'h10C, 32'h0,        4'b1111, 3'd2, -1, -1, 32'h0,       32'h0,        32'h0,        1'b1, 17, 16);

        @(negedge clk);
        check("to_req_after_err", {31'b0, bus_err}, 32'h0);
        check("to_req_after_stall", {31'b0, mem_stall}, 32'h0);
        check("to_req_after_req", {31'b0, bus_if.bus_req}, 32'h0);

        run_txn("lw_pre",   1'b0, 1'b1, 32'h010, 32'h0,        4'b1111, 3'd2, 0, 0,  32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 1'b0, 2,  1);
        run_txn("to_waitr", 1'b0, 1'b1, 32'h014, 32'h0,        4'b1111, 3'd2, 0, -1, 32'h0,        32'h0,        32'h0,        1'b1, 18, 1);
        run_txn("lw_rst",   1'b0, 1'b1, 32'h018, 32'h0,        4'b1111, 3'd2, 0, 1,  32'h55AA1234, 32'h0,        32'h55AA1234, 1'b0, 3,  1);

        // Reset while WAIT_R is outstanding, then a stale rvalid after release.
        @(negedge clk);
        dmem_re = 1'b1; dmem_funct3 = 3'd2; dmem_addr = 32'h200; dmem_be = 4'b1111;
        @(negedge clk);
        dmem_re = 1'b0;
        check("mid_req", {31'b0, bus_if.bus_req}, 32'h1);
        bus_if.bus_gnt = 1'b1;
        @(negedge clk);
        bus_if.bus_gnt = 1'b0;
        check("mid_waitr_req", {31'b0, bus_if.bus_req}, 32'h0);
        check("mid_waitr_stall", {31'b0, mem_stall}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_bus_req", {31'b0, bus_if.bus_req}, 32'h0);
        check("arst_mem_stall", {31'b0, mem_stall}, 32'h0);
        check("arst_load_data", load_data, 32'h0);
        check("arst_bus_addr", bus_if.bus_addr, 32'h0);
        check("arst_bus_wdata", bus_if.bus_wdata, 32'h0);
        check("arst_flags", {27'b0, bus_if.bus_be[0], load_valid, bus_err, misalign_err, bus_if.bus_we}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'hFFFF0000;
        @(negedge clk);
        bus_if.bus_rvalid = 1'b0;
        check("late_rv_valid", {31'b0, load_valid}, 32'h0);
        check("late_rv_data", load_data, 32'h0);
        check("late_rv_stall", {31'b0, mem_stall}, 32'h0);
        @(negedge clk);
        check("late_rv_valid2", {31'b0, load_valid}, 32'h0);
        check("late_rv_req2", {31'b0, bus_if.bus_req}, 32'h0);
        $display("txn reset_mid_waitr load_data=0x%08h load_valid=%0b", load_data, load_valid);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_bus_bridge.md
Name: dmem_bus_bridge

Overview:
Sits directly downstream of the MEM stage and consumes its data-memory request (address, write data, write enable, byte enables, funct3, plus a load enable). It converts each request into a multi-cycle valid/grant transaction on a word-addressed data bus, stalling the pipeline until the transaction completes. It then returns load data to WB, already aligned and sign- or zero-extended.

Parameters:
XLEN, 32, data width (bits)
ALEN, 32, address width (bits)
BUS_TIMEOUT, 16, max cycles waiting for bus_gnt or bus_rvalid before aborting; 0 disables timeout

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
dmem_addr  in  ALEN  byte address from MEM stage
dmem_wdata  in  XLEN  unshifted store data (rs2, forwarded)
dmem_we  in  1  store request
dmem_re  in  1  load request
dmem_be  in  4  byte enables from MEM stage
dmem_funct3  in  3  access type (LB/LH/LW/LBU/LHU, SB/SH/SW)
mem_stall  out  1  freeze IF..MEM while a transaction is outstanding
load_data  out  XLEN  extended load result to WB
load_valid  out  1  one-cycle pulse: load_data updated
bus_err  out  1  one-cycle pulse: transaction timed out
misalign_err  out  1  one-cycle pulse: misaligned access (optional feature)
bus_req  out  1  bus request valid
bus_we  out  1  bus write
bus_addr  out  ALEN  word-aligned address, {addr[ALEN-1:2],2'b00}
bus_wdata  out  XLEN  lane-replicated store data
bus_be  out  4  byte enables to bus
bus_gnt  in  1  bus accepted request
bus_rvalid  in  1  read data valid
bus_rdata  in  XLEN  read data word

Behaviour:
- Reset (async on rst_n low, any state): state=IDLE; bus_req, bus_we, bus_addr, bus_wdata, bus_be, load_data, load_valid, bus_err, misalign_err, mem_stall all 0; timeout counter 0. Reset mid-transaction drops bus_req immediately. Any late gnt/rvalid after reset is ignored.
- FSM states: IDLE, REQ, WAIT_R, DONE.
- IDLE: if dmem_we|dmem_re, mem_stall=1 combinationally in the same cycle. Latch addr, funct3, be, we and replicated wdata, then go to REQ. Replication: byte={4{wdata[7:0]}}, half={2{wdata[15:0]}}, word unchanged. If we and re are both 1, the access is treated as a store.
- REQ: bus_req=1 and all bus outputs held stable until bus_gnt.
  - Store with gnt: go to DONE.
  - Load with gnt and no rvalid: go to WAIT_R.
  - Load with gnt and rvalid in the same cycle: capture data and go to DONE.
- WAIT_R: bus_req=0; on bus_rvalid, capture bus_rdata and go to DONE.
- Load extraction: select byte addr[1:0] or half addr[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- DONE: mem_stall=0 for exactly one cycle so the pipeline advances.
  - load_valid=1 for a completed load, with load_data registered.
  - No new request is accepted in DONE; next state is always IDLE.
- Latency: store = 1 (IDLE) + gnt wait + 1 (DONE), i.e. minimum 3 cycles with mem_stall high for 2. Load with rvalid one cycle after gnt = minimum 4 cycles.
- Timeout: counter clears on entering REQ/WAIT_R and increments each cycle without the awaited event. At count==BUS_TIMEOUT-1 with no event: go to DONE, pulse bus_err, set load_data=0, drop bus_req.
- load_data holds its value until the next completed load or a timeout.

Optional Feature:
DMEM_MISALIGN_CHECK_EN
- Defined: in IDLE, a half access with addr[0]=1 or a word access with addr[1:0]!=0 issues no bus transaction. The FSM goes straight to DONE (stall for 1 cycle), pulses misalign_err, sets load_data=0 for loads, and asserts no load_valid.
- Undefined: misalign_err is tied 0; word accesses ignore addr[1:0]; half accesses use addr[1] only.

Test Plan:
- SW addr 0x100, wdata 0xDEADBEEF, gnt after 2 cycles -> bus_addr 0x100, be 4'b1111, bus_req high 2 cycles, mem_stall high 3 cycles, then DONE with stall 0.
- SB addr 0x103, wdata 0x000000A5 -> bus_wdata 0xA5A5A5A5, bus_be 4'b1000, bus_addr 0x100.
- LB addr 0x102, rdata 0x12805634 -> load_data 0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x102 -> 0x00001280.
- LW with gnt and rvalid in the same cycle, rdata 0xCAFEF00D -> DONE the next cycle, load_valid pulse, load_data 0xCAFEF00D.
- Load with gnt never asserted, BUS_TIMEOUT=16 -> bus_err pulse after 16 REQ cycles, load_data 0, FSM back in IDLE.
- rst_n low while in WAIT_R, then rvalid arrives after release -> bus_req 0 immediately, no load_valid, all outputs 0.
